// File: rtl/t06_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : t06_game_ctrl
//  Description : Snake game state controller. Converts start/speed buttons
//                and body-logic events into game_state / game_speed codes,
//                and keeps score and win/lose flags for the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module t06_game_ctrl #(
    parameter int MAX_SCORE = 50
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       button_start,
    input  logic       button_speed,
    input  logic       apple_eaten,
    input  logic       collision,
    output logic [1:0] game_state,
    output logic [1:0] game_speed,
    output logic [7:0] score,
    output logic       win,
    output logic       lose
);

    // Internal FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_over  = 2'd3;

    // Externally visible game_state codes
    localparam logic [1:0] c_gs_run  = 2'b00;
    localparam logic [1:0] c_gs_hold = 2'b01;
    localparam logic [1:0] c_gs_over = 2'b10;

    localparam logic [7:0] c_max_score = 8'(MAX_SCORE);

    // Button path, bit 0 = start, bit 1 = speed
    logic [1:0] w_buttons;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] r_prev;
    logic [1:0] r_vld;    // shifts in ones after reset until r_sync holds a real sample
    logic [1:0] r_armed;  // set once a released button has been seen
    logic [1:0] w_pulse;
    logic       w_start;
    logic       w_speed;

    // Registered game state
    logic [1:0] r_state;
    logic [1:0] r_game_state;
    logic [1:0] r_speed;
    logic [7:0] r_score;
    logic       r_win;
    logic       r_lose;

    // Next-state values
    logic [1:0] w_state_nxt;
    logic [1:0] w_game_state_nxt;
    logic [1:0] w_speed_nxt;
    logic [7:0] w_score_nxt;
    logic       w_win_nxt;
    logic       w_lose_nxt;
    logic [7:0] w_score_inc;

    assign w_buttons   = {button_speed, button_start};
    // A button that was already held through reset must be released before
    // it can produce a pulse, so edges only count once the button is armed.
    assign w_pulse     = r_sync & ~r_prev & r_armed;
    assign w_start     = w_pulse[0];
    assign w_speed     = w_pulse[1];
    assign w_score_inc = r_score + 8'd1;

    // Synchronize raw buttons, remember previous value, and arm on release
    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_meta  <= 2'b00;
            r_sync  <= 2'b00;
            r_prev  <= 2'b00;
            r_vld   <= 2'b00;
            r_armed <= 2'b00;
        end else begin
            r_meta  <= w_buttons;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | ({2{r_vld[1]}} & ~r_sync);
        end
    end

    // Next-state, speed, score and flag decisions
    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_score_nxt = r_score;
        w_win_nxt   = r_win;
        w_lose_nxt  = r_lose;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_state_nxt = c_st_run;
                    w_score_nxt = 8'd0;
                end else if (w_speed) begin
                    case (r_speed)
                        2'b00:   w_speed_nxt = 2'b01;
                        2'b01:   w_speed_nxt = 2'b10;
                        default: w_speed_nxt = 2'b00;
                    endcase
                end
            end
            c_st_run: begin
                // Collision beats apple; either event swallows a start press
                if (collision) begin
                    w_state_nxt = c_st_over;
                    w_lose_nxt  = 1'b1;
                end else if (apple_eaten) begin
                    w_score_nxt = w_score_inc;
                    if (w_score_inc == c_max_score) begin
                        w_state_nxt = c_st_over;
                        w_win_nxt   = 1'b1;
                    end
                end else if (w_start) begin
                    w_state_nxt = c_st_pause;
                end
            end
            c_st_pause: begin
                if (w_start) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_over: begin
                if (w_start) begin
                    w_state_nxt = c_st_idle;
                    w_score_nxt = 8'd0;
                    w_win_nxt   = 1'b0;
                    w_lose_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        case (w_state_nxt)
            c_st_run:  w_game_state_nxt = c_gs_run;
            c_st_over: w_game_state_nxt = c_gs_over;
            default:   w_game_state_nxt = c_gs_hold;
        endcase
    end

    // State and output registers
    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_game_state <= c_gs_hold;
            r_speed      <= 2'b00;
            r_score      <= 8'd0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_game_state <= w_game_state_nxt;
            r_speed      <= w_speed_nxt;
            r_score      <= w_score_nxt;
            r_win        <= w_win_nxt;
            r_lose       <= w_lose_nxt;
        end
    end

    assign game_state = r_game_state;
    assign game_speed = r_speed;
    assign score      = r_score;
    assign win        = r_win;
    assign lose       = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_t06_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t06_game_ctrl
//  Description : Directed self-checking bench for t06_game_ctrl. One instance
//                uses the default MAX_SCORE, a second uses MAX_SCORE=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t06_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1, bst = 1'b0, bsp = 1'b0, ae = 1'b0, col = 1'b0;
    logic       rst4 = 1'b1, bst4 = 1'b0, bsp4 = 1'b0, ae4 = 1'b0, col4 = 1'b0;
    logic [1:0] gs, spd, gs4, spd4;
    logic [7:0] sc, sc4;
    logic       wn, ls, wn4, ls4;
    int         n_checks = 0;
    int         n_fail   = 0;

    t06_game_ctrl dut (
        .system_clk  (clk),
        .reset       (rst),
        .button_start(bst),
        .button_speed(bsp),
        .apple_eaten (ae),
        .collision   (col),
        .game_state  (gs),
        .game_speed  (spd),
        .score       (sc),
        .win         (wn),
        .lose        (ls)
    );

    t06_game_ctrl #(.MAX_SCORE(4)) dut4 (
        .system_clk  (clk),
        .reset       (rst4),
        .button_start(bst4),
        .button_speed(bsp4),
        .apple_eaten (ae4),
        .collision   (col4),
        .game_state  (gs4),
        .game_speed  (spd4),
        .score       (sc4),
        .win         (wn4),
        .lose        (ls4)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Button high for one sample, then wait until outputs have reacted (edge N+2)
    task automatic press_start();
        bst = 1'b1; tick(); bst = 1'b0; tick(); tick();
    endtask

    task automatic press_speed();
        bsp = 1'b1; tick(); bsp = 1'b0; tick(); tick();
    endtask

    task automatic press_start4();
        bst4 = 1'b1; tick(); bst4 = 1'b0; tick(); tick();
    endtask

    task automatic apple();
        ae = 1'b1; tick(); ae = 1'b0;
    endtask

    task automatic crash();
        col = 1'b1; tick(); col = 1'b0;
    endtask

    task automatic apple4();
        ae4 = 1'b1; tick(); ae4 = 1'b0;
    endtask

    initial begin
        // ---- 1. reset and speed select ----
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_state", 32'(gs), 32'd1);
        chk("rst_speed", 32'(spd), 32'd0);
        chk("rst_score", 32'(sc), 32'd0);
        chk("rst_flags", 32'({wn, ls}), 32'd0);

        bsp = 1'b1; tick(); bsp = 1'b0; tick();
        chk("speed_latency_n1", 32'(spd), 32'd0);
        tick();
        chk("speed_press1", 32'(spd), 32'd1);
        press_speed();
        chk("speed_press2", 32'(spd), 32'd2);
        press_speed();
        chk("speed_press3", 32'(spd), 32'd0);
        press_speed();
        chk("speed_press4", 32'(spd), 32'd1);

        // ---- 2. normal play to loss ----
        press_start();
        chk("start_run_state", 32'(gs), 32'd0);
        chk("start_run_score", 32'(sc), 32'd0);
        apple(); chk("apple1", 32'(sc), 32'd1);
        apple(); chk("apple2", 32'(sc), 32'd2);
        apple(); chk("apple3", 32'(sc), 32'd3);
        chk("run_state", 32'(gs), 32'd0);
        crash();
        chk("loss_state", 32'(gs), 32'd2);
        chk("loss_lose", 32'(ls), 32'd1);
        chk("loss_win", 32'(wn), 32'd0);
        chk("loss_score", 32'(sc), 32'd3);
        press_start();
        chk("over_idle_state", 32'(gs), 32'd1);
        chk("over_idle_score", 32'(sc), 32'd0);
        chk("over_idle_lose", 32'(ls), 32'd0);
        chk("over_idle_speed", 32'(spd), 32'd1);

        // ---- 4. pause ----
        press_start();
        apple(); chk("pre_pause_score", 32'(sc), 32'd1);
        press_start();
        chk("pause_state", 32'(gs), 32'd1);
        apple(); crash(); tick();
        chk("pause_ignore_score", 32'(sc), 32'd1);
        chk("pause_ignore_state", 32'(gs), 32'd1);
        chk("pause_ignore_lose", 32'(ls), 32'd0);
        press_start();
        chk("resume_state", 32'(gs), 32'd0);
        chk("resume_score", 32'(sc), 32'd1);

        // ---- 5. simultaneous events ----
        apple(); chk("pre_sim_score", 32'(sc), 32'd2);
        ae = 1'b1; col = 1'b1; tick(); ae = 1'b0; col = 1'b0;
        chk("sim_ev_state", 32'(gs), 32'd2);
        chk("sim_ev_lose", 32'(ls), 32'd1);
        chk("sim_ev_score", 32'(sc), 32'd2);
        press_start();
        chk("sim_idle", 32'(gs), 32'd1);
        bst = 1'b1; bsp = 1'b1; tick(); bst = 1'b0; bsp = 1'b0; tick(); tick();
        chk("sim_btn_state", 32'(gs), 32'd0);
        chk("sim_btn_speed", 32'(spd), 32'd1);

        // Start held for 100 cycles: one RUN->PAUSE transition only
        bst = 1'b1; tick(); tick(); tick();
        chk("held_first", 32'(gs), 32'd1);
        repeat (97) tick();
        chk("held_end", 32'(gs), 32'd1);
        bst = 1'b0; tick(); tick(); tick();
        chk("held_release", 32'(gs), 32'd1);

        // ---- 6. reset mid-game ----
        press_start(); crash(); press_start();
        press_speed();
        chk("pre_rst_speed", 32'(spd), 32'd2);
        press_start();
        repeat (5) apple();
        chk("pre_rst_score", 32'(sc), 32'd5);
        chk("pre_rst_state", 32'(gs), 32'd0);
        rst = 1'b1; col = 1'b1; tick(); rst = 1'b0; col = 1'b0;
        chk("midrst_state", 32'(gs), 32'd1);
        chk("midrst_score", 32'(sc), 32'd0);
        chk("midrst_speed", 32'(spd), 32'd0);
        chk("midrst_lose", 32'(ls), 32'd0);
        tick(); tick(); tick();

        // Start held across reset release must not start a game
        bst = 1'b1; rst = 1'b1; tick(); tick(); rst = 1'b0;
        repeat (6) tick();
        chk("held_thru_rst", 32'(gs), 32'd1);
        bst = 1'b0; tick(); tick(); tick();
        press_start();
        chk("press_after_rel", 32'(gs), 32'd0);

        // ---- 3. win with MAX_SCORE=4 ----
        rst4 = 1'b0;
        tick(); tick(); tick();
        chk("w4_rst_state", 32'(gs4), 32'd1);
        press_start4();
        chk("w4_run", 32'(gs4), 32'd0);
        apple4(); apple4(); apple4();
        chk("w4_score3", 32'(sc4), 32'd3);
        chk("w4_state3", 32'(gs4), 32'd0);
        apple4();
        chk("w4_score4", 32'(sc4), 32'd4);
        chk("w4_state4", 32'(gs4), 32'd2);
        chk("w4_win", 32'(wn4), 32'd1);
        chk("w4_lose", 32'(ls4), 32'd0);
        apple4();
        chk("w4_score5", 32'(sc4), 32'd4);
        chk("w4_state5", 32'(gs4), 32'd2);
        press_start4();
        chk("w4_idle_state", 32'(gs4), 32'd1);
        chk("w4_idle_win", 32'(wn4), 32'd0);
        chk("w4_idle_score", 32'(sc4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t06_game_ctrl.md
# t06_game_ctrl

Top-level game state controller for the team_06 snake game. It turns the start and speed buttons plus body-logic events (apple eaten, collision) into the `game_state` and `game_speed` codes that drive the tick generator, and keeps the score and win/lose flags for the display. It is the producer side of the `game_state`/`game_speed` interface; the tick generator is the consumer.

## Interface

- `MAX_SCORE`, default 50: score at which the game is won; legal range 1..255.
- `system_clk` input 1: single system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `button_start` input 1: raw, asynchronous start/pause button, active-high.
- `button_speed` input 1: raw, asynchronous speed-select button, active-high.
- `apple_eaten` input 1: one-cycle pulse from body logic, `system_clk` domain.
- `collision` input 1: one-cycle pulse from body logic (wall/self hit), `system_clk` domain.
- `game_state` output 2: 00 RUN, 01 HOLD (idle or paused), 10 OVER; 11 is never driven.
- `game_speed` output 2: 00 normal, 01 fast, 10 slow; 11 is never driven.
- `score` output 8: binary apples eaten in the current game.
- `win` output 1: high in OVER when the score reached `MAX_SCORE`.
- `lose` output 1: high in OVER when the game ended by collision.

## Operation

- **Button path.** Each button passes through a 2-flop synchronizer and then a rising-edge detector (previous-value flop). This yields one internal pulse per press. A held button produces no repeats.
- **FSM.** Four internal states: IDLE, RUN, PAUSE, OVER. Output encoding: IDLE→01, PAUSE→01, RUN→00, OVER→10.
- **IDLE**
  - start pulse → RUN; score is cleared on this transition.
  - speed pulse (with no start pulse) → `game_speed` cycles 00→01→10→00.
  - start has priority; a simultaneous speed pulse is dropped.
- **RUN**
  - collision → OVER, lose=1.
  - apple_eaten → score+1. If the new score equals `MAX_SCORE` → OVER, win=1.
  - collision and apple_eaten in the same cycle → collision wins. Score is unchanged, lose=1.
  - start pulse → PAUSE, unless collision or apple_eaten is also present. Those events take priority, and the start pulse is dropped.
- **PAUSE**
  - start pulse → RUN; score is retained.
  - apple_eaten and collision are ignored.
- **OVER**
  - start pulse → IDLE; score, win and lose are cleared.
- **Speed button** is ignored in RUN, PAUSE and OVER. `game_speed` is preserved across games and only reset clears it.
- **Score** never exceeds `MAX_SCORE`. No wrap is possible because reaching `MAX_SCORE` forces OVER.
- win and lose are mutually exclusive and are only ever high in OVER.

## Timing

- Reset values: FSM=IDLE (`game_state`=01), `game_speed`=00, `score`=0, `win`=0, `lose`=0. Synchronizer and edge flops are also cleared.
- Reset asserted mid-game takes effect at the next rising edge and overrides every other input in that cycle.
- Button latency: the button is high at edge N (first sample). The internal pulse exists between edges N+1 and N+2. Outputs change at edge N+2. If the button was high before reset release, no pulse is generated until it is released and pressed again.
- Event latency: `apple_eaten`/`collision` high during the cycle before edge N → `score`/`game_state`/flags update at edge N. No synchronizer is used.
- All outputs are registered; no output is combinational from any input.
- `apple_eaten`/`collision` held high for k cycles in RUN are treated as k events. The first collision ends the game.

## Test plan

1. **Reset and speed select:** assert reset for 2 cycles, then press `button_speed` 4 times (each 1 press, released between presses).
   - After reset: `game_state`=01, `game_speed`=00, `score`=0.
   - After the presses: `game_speed` steps 01, 10, 00, 01, each change 2 edges after its press.
2. **Normal play to loss:** start press, then 3 `apple_eaten` pulses, then 1 `collision` pulse.
   - `game_state`=00 and `score`=3, then `game_state`=10 with lose=1, win=0, `score` held at 3.
   - A further start press gives `game_state`=01, `score`=0, lose=0; `game_speed` is unchanged.
3. **Win, with `MAX_SCORE`=4:** start press, then 4 `apple_eaten` pulses.
   - On the 4th pulse: `score`=4, `game_state`=10, win=1.
   - A 5th `apple_eaten` pulse leaves `score` at 4.
4. **Pause:** in RUN, press start.
   - `game_state`=01.
   - `apple_eaten` and `collision` pulses during PAUSE leave `score` and state unchanged.
   - A second start press gives `game_state`=00 with the score retained.
5. **Simultaneous events:**
   - In RUN with `score`=2: `apple_eaten` and `collision` in the same cycle → OVER, lose=1, `score`=2.
   - In IDLE: start and speed pressed together → RUN, `game_speed` unchanged.
   - A button held for 100 cycles yields exactly one transition.
6. **Reset mid-game:** in RUN with `score`=5 and `game_speed`=10, assert reset for 1 cycle together with a `collision` pulse.
   - Result: `game_state`=01, `score`=0, `game_speed`=00, lose=0.
